// File: rtl/fewcore_pkg.sv
// Shared fewcore pipeline definitions: register addressing, tracker entry layout,
// forwarding-select encoding and the producer/reader match rule.
package fewcore_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  // Forwarding select value meaning "read the register bank".
  localparam int FWD_SRC_BANK = 0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              is_load;
  } trk_entry_t;

  localparam int TRK_ENTRY_W = $bits(trk_entry_t);

  // x0 is hard-wired to zero, so a write to it can never feed a reader.
  function automatic logic ent_matches(input trk_entry_t e, input logic [REG_AW-1:0] rs);
    return e.valid & e.wen & (e.rd == rs) & (rs != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer priority encoder for one source operand: returns {hit, stage, is_load}.
// Purely combinational, zero latency; no backpressure of its own.
module hazard_match
  import fewcore_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0]           rs,
  input  trk_entry_t [DEPTH-1:0]      ent,
  output logic                        hit,
  output logic [SEL_W-1:0]            k,
  output logic                        is_load
);

  // Walk oldest to youngest so the youngest (smallest stage) match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    k       = SEL_W'(FWD_SRC_BANK);
    is_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_matches(ent[i], rs)) begin
        hit     = 1'b1;
        k       = SEL_W'(i + 1);
        is_load = ent[i].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Operand forwarding select, load-use stall and branch flush for the fewcore pipeline.
// Outputs combinational from decode + tracker; stall holds decode, flush discards it.
module hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  parameter int FSEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_wen,
  input  logic              dec_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic              issue,
  output logic [FSEL_W-1:0] fwd_rs1,
  output logic [FSEL_W-1:0] fwd_rs2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import fewcore_pkg::*;

  if (FWD_DEPTH < 1) begin : g_chk_depth
    $fatal(1, "hazard_unit: FWD_DEPTH must be at least 1");
  end
  if (LOAD_LAT < 0 || LOAD_LAT > FWD_DEPTH - 1) begin : g_chk_lat
    $fatal(1, "hazard_unit: LOAD_LAT must lie in 0..FWD_DEPTH-1");
  end
  if (REG_AW != fewcore_pkg::REG_AW) begin : g_chk_aw
    $fatal(1, "hazard_unit: REG_AW must match the fewcore register file");
  end
  if (FSEL_W != $clog2(FWD_DEPTH + 1)) begin : g_chk_fsel
    $fatal(1, "hazard_unit: FSEL_W is derived and must not be overridden");
  end

  localparam logic [FSEL_W-1:0] LU_MAX_STAGE = FSEL_W'(LOAD_LAT);

  trk_entry_t                 trk_q [FWD_DEPTH];
  trk_entry_t [FWD_DEPTH-1:0] trk_vec;
  trk_entry_t                 dec_ent;

  logic              m1_hit, m1_ld, m2_hit, m2_ld;
  logic [FSEL_W-1:0] m1_k, m2_k;
  logic              lu_rs1, lu_rs2;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  always_comb begin
    dec_ent         = '0;
    dec_ent.valid   = 1'b1;
    dec_ent.rd      = dec_rd;
    dec_ent.wen     = dec_wen;
    dec_ent.is_load = dec_is_load;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      trk_vec[i] = trk_q[i];
    end
  end

  // Stage 1 takes the decode instruction or a bubble; older stages just shift.
  for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_trk
    if (g == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset)      trk_q[0] <= '0;
        else if (issue) trk_q[0] <= dec_ent;
        else            trk_q[0] <= '0;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset) trk_q[g] <= '0;
        else       trk_q[g] <= trk_q[g-1];
      end
    end
  end

  hazard_match #(
    .DEPTH (FWD_DEPTH),
    .SEL_W (FSEL_W)
  ) u_match_rs1 (
    .rs      (dec_rs1),
    .ent     (trk_vec),
    .hit     (m1_hit),
    .k       (m1_k),
    .is_load (m1_ld)
  );

  hazard_match #(
    .DEPTH (FWD_DEPTH),
    .SEL_W (FSEL_W)
  ) u_match_rs2 (
    .rs      (dec_rs2),
    .ent     (trk_vec),
    .hit     (m2_hit),
    .k       (m2_k),
    .is_load (m2_ld)
  );

  // Load data is not ready until it has left stage LOAD_LAT.
  assign lu_rs1 = m1_hit & m1_ld & (m1_k <= LU_MAX_STAGE);
  assign lu_rs2 = m2_hit & m2_ld & (m2_k <= LU_MAX_STAGE);

  always_comb begin
    flush   = 1'b0;
    stall   = 1'b0;
    issue   = 1'b0;
    fwd_rs1 = FSEL_W'(FWD_SRC_BANK);
    fwd_rs2 = FSEL_W'(FWD_SRC_BANK);
    if (!reset) begin
      flush   = br_taken;
      stall   = dec_valid & ~br_taken & (lu_rs1 | lu_rs2);
      issue   = dec_valid & ~stall & ~flush;
      fwd_rs1 = m1_k;
      fwd_rs2 = m2_k;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
